// File: rtl/irq_encoder8.sv
// Sticky 8-request capture with priority encode into a held valid/ready code.
// Latency: req edge k -> pending after k, out_valid after k+1; one bubble per accept.
// Backpressure: code frozen while out_ready=0; later requests accumulate in pending.
module irq_encoder8 #(
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] req,
    output logic [2:0] out_code,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] pending,
    output logic       overflow
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t     state;
    logic       fire;
    logic [7:0] clr;
    logic [7:0] req_gated;
    logic [2:0] enc_code;

    function automatic logic [2:0] prio_enc(input logic [7:0] vec);
        logic [2:0] code;
        code = 3'd0;
        if (LSB_FIRST) begin
            for (int i = 7; i >= 0; i--) begin
                if (vec[i]) code = 3'(i);
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (vec[i]) code = 3'(i);
            end
        end
        return code;
    endfunction

    always_comb begin
        fire      = (state == HOLD) && out_ready;
        clr       = fire ? (8'h01 << out_code) : 8'h00;
        req_gated = en ? req : 8'h00;
        enc_code  = prio_enc(pending);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            pending   <= 8'h00;
            out_code  <= 3'd0;
            out_valid <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            // A new event on the bit being accepted survives the clear.
            pending  <= (pending & ~clr) | req_gated;
            overflow <= |(req_gated & pending & ~clr);
            case (state)
                IDLE: begin
                    if (pending != 8'h00) begin
                        out_code  <= enc_code;
                        out_valid <= 1'b1;
                        state     <= HOLD;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
